// File: rtl/snow_v_pkg.sv
// Shared constants and state encoding for the SNOW_V keystream XOR stage.
package snow_v_pkg;

   localparam int SNOW_V_BLK_W  = 128;
   localparam int SNOW_V_KEEP_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/snow_v_ks_fifo.sv
// Keystream buffer: synchronous FIFO with first-word-fall-through head.
module snow_v_ks_fifo #(
   parameter int DATA_W = 128,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW:0]       r_wr_ptr;
   logic [AW:0]       r_rd_ptr;
   logic              w_push;
   logic              w_pop;

   // Pointer MSB differs only when the write side has lapped the read side.
   assign empty = (r_wr_ptr == r_rd_ptr);
   assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;
   assign dout   = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
      end
   end

endmodule

// File: rtl/snow_v_xor_stage.sv
// XORs message blocks with buffered SNOW_V keystream words, one word
// per block, with valid/ready on both sides and a registered output.
module snow_v_xor_stage
   import snow_v_pkg::*;
#(
   parameter int DATA_W     = SNOW_V_BLK_W,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [DATA_W-1:0]   ks_in,
   input  logic                ks_valid,
   output logic                ks_ready,
   input  logic [DATA_W-1:0]   pt_data,
   input  logic [DATA_W/8-1:0] pt_keep,
   input  logic                pt_last,
   input  logic                pt_valid,
   output logic                pt_ready,
   output logic [DATA_W-1:0]   ct_data,
   output logic [DATA_W/8-1:0] ct_keep,
   output logic                ct_last,
   output logic                ct_valid,
   input  logic                ct_ready,
   output logic                busy,
   output logic                done,
   output logic [CNT_W-1:0]    block_cnt
);

   localparam int KEEP_W = DATA_W / 8;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   state_t              r_state;
   logic                r_ct_valid;
   logic [DATA_W-1:0]   r_ct_data;
   logic [KEEP_W-1:0]   r_ct_keep;
   logic                r_ct_last;
   logic                r_done;
   logic [CNT_W-1:0]    r_blk_cnt;

   logic [DATA_W-1:0]   w_ks_head;
   logic                w_fifo_full;
   logic                w_fifo_empty;
   logic                w_run;
   logic                w_ks_push;
   logic                w_pt_hs;
   logic                w_ct_hs;
   logic                w_flush;
   logic [DATA_W-1:0]   w_mask;
   logic [DATA_W-1:0]   w_ct_next;

   assign w_run     = (r_state == RUN);
   assign ks_ready  = w_run & ~w_fifo_full;
   assign pt_ready  = w_run & ~w_fifo_empty &
                      (~r_ct_valid | ct_ready);
   assign w_ks_push = ks_valid & ks_ready;
   assign w_pt_hs   = pt_valid & pt_ready;
   assign w_ct_hs   = r_ct_valid & ct_ready;

   // Leftover keystream never carries over between messages.
   assign w_flush = ((r_state == IDLE) & start) |
                    ((r_state == DRAIN) & w_ct_hs);

   always_comb begin
      w_mask = '0;
      for (int i = 0; i < KEEP_W; i++) begin
         w_mask[8*i +: 8] = {8{pt_keep[i]}};
      end
   end

   assign w_ct_next = (pt_data ^ w_ks_head) & w_mask;

   snow_v_ks_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_ks_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (w_flush),
      .push  (w_ks_push),
      .din   (ks_in),
      .pop   (w_pt_hs),
      .dout  (w_ks_head),
      .full  (w_fifo_full),
      .empty (w_fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_ct_valid <= 1'b0;
         r_ct_data  <= '0;
         r_ct_keep  <= '0;
         r_ct_last  <= 1'b0;
         r_done     <= 1'b0;
         r_blk_cnt  <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_state    <= RUN;
                  r_blk_cnt  <= '0;
                  r_ct_valid <= 1'b0;
               end
            end
            RUN: begin
               if (w_pt_hs) begin
                  r_ct_valid <= 1'b1;
                  r_ct_data  <= w_ct_next;
                  r_ct_keep  <= pt_keep;
                  r_ct_last  <= pt_last;
                  r_blk_cnt  <= r_blk_cnt + CNT_ONE;
                  if (pt_last) begin
                     r_state <= DRAIN;
                  end
               end else if (w_ct_hs) begin
                  r_ct_valid <= 1'b0;
               end
            end
            DRAIN: begin
               if (w_ct_hs) begin
                  r_state    <= IDLE;
                  r_ct_valid <= 1'b0;
                  r_done     <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign ct_data   = r_ct_data;
   assign ct_keep   = r_ct_keep;
   assign ct_last   = r_ct_last;
   assign ct_valid  = r_ct_valid;
   assign done      = r_done;
   assign block_cnt = r_blk_cnt;
   assign busy      = (r_state == RUN) | (r_state == DRAIN);

endmodule

// File: tb/tb_snow_v_xor_stage.sv
// Randomized bench for snow_v_xor_stage against a queue-based
// model of keystream buffering and per-block XOR masking.
module tb_snow_v_xor_stage;

   typedef struct {
      logic [127:0] d;
      logic [15:0]  k;
      logic         l;
   } blk_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [127:0] ks_in = '0;
   logic         ks_valid = 1'b0;
   logic         ks_ready;
   logic [127:0] pt_data = '0;
   logic [15:0]  pt_keep = '0;
   logic         pt_last = 1'b0;
   logic         pt_valid = 1'b0;
   logic         pt_ready;
   logic [127:0] ct_data;
   logic [15:0]  ct_keep;
   logic         ct_last;
   logic         ct_valid;
   logic         ct_ready = 1'b0;
   logic         busy;
   logic         done;
   logic [31:0]  block_cnt;

   snow_v_xor_stage dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .ks_in     (ks_in),
      .ks_valid  (ks_valid),
      .ks_ready  (ks_ready),
      .pt_data   (pt_data),
      .pt_keep   (pt_keep),
      .pt_last   (pt_last),
      .pt_valid  (pt_valid),
      .pt_ready  (pt_ready),
      .ct_data   (ct_data),
      .ct_keep   (ct_keep),
      .ct_last   (ct_last),
      .ct_valid  (ct_valid),
      .ct_ready  (ct_ready),
      .busy      (busy),
      .done      (done),
      .block_cnt (block_cnt)
   );

   initial forever #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   // Model: 0 idle, 1 run, 2 drain
   int           m_st = 0;
   logic [127:0] m_q[$];
   blk_t         m_exp[$];
   bit           m_ctv = 0;
   bit           m_done = 0;
   logic [31:0]  m_cnt = 0;
   bit           m_pt_hs = 0;
   int           dut_hs_n = 0;

   logic [127:0] b_data [16];
   logic [15:0]  b_keep [16];
   int           n_blk = 0;
   int           b_idx = 0;

   task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   function automatic logic [127:0] rnd();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic logic [127:0] ref_xor(logic [127:0] p,
                                            logic [127:0] k,
                                            logic [15:0] keep);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++)
         if (keep[i]) r[8*i +: 8] = p[8*i +: 8] ^ k[8*i +: 8];
      return r;
   endfunction

   task automatic model_reset();
      m_st = 0;
      m_q.delete();
      m_exp.delete();
      m_ctv = 0;
      m_done = 0;
      m_cnt = 0;
   endtask

   task automatic tick();
      bit   ks_r, pt_r, ks_hs, pt_hs, ct_hs;
      blk_t b;
      #1;
      ks_r = (m_st == 1) && (m_q.size() < 4);
      pt_r = (m_st == 1) && (m_q.size() > 0) && (!m_ctv || ct_ready);
      chk("ks_ready", ks_ready, ks_r);
      chk("pt_ready", pt_ready, pt_r);
      chk("ct_valid", ct_valid, m_ctv);
      chk("busy", busy, m_st != 0);
      chk("done", done, m_done);
      chk("block_cnt", block_cnt, m_cnt);
      if (m_ctv) begin
         chk("ct_data", ct_data, m_exp[0].d);
         chk("ct_keep", ct_keep, m_exp[0].k);
         chk("ct_last", ct_last, m_exp[0].l);
      end
      if (ct_valid && ct_ready) dut_hs_n++;
      ks_hs = ks_valid && ks_r;
      pt_hs = pt_valid && pt_r;
      ct_hs = m_ctv && ct_ready;
      m_done = (m_st == 2) && ct_hs;
      m_pt_hs = pt_hs;
      case (m_st)
         0: if (start) begin
            m_st = 1;
            m_cnt = 0;
            m_ctv = 0;
            m_q.delete();
            m_exp.delete();
         end
         1: begin
            if (ct_hs) m_exp.delete(0);
            if (pt_hs) begin
               b.d = ref_xor(pt_data, m_q.pop_front(), pt_keep);
               b.k = pt_keep;
               b.l = pt_last;
               m_exp.push_back(b);
               m_cnt++;
               if (pt_last) m_st = 2;
            end
            m_ctv = pt_hs ? 1'b1 : (ct_hs ? 1'b0 : m_ctv);
            if (ks_hs) m_q.push_back(ks_in);
         end
         default: if (ct_hs) begin
            m_exp.delete(0);
            m_st = 0;
            m_ctv = 0;
            m_q.delete();
         end
      endcase
      @(negedge clk);
   endtask

   task automatic drive(bit want_pt, bit ksv, bit ctr, logic [127:0] ks);
      ks_valid = ksv;
      ks_in = ks;
      ct_ready = ctr;
      pt_valid = want_pt && (b_idx < n_blk);
      if (b_idx < n_blk) begin
         pt_data = b_data[b_idx];
         pt_keep = b_keep[b_idx];
         pt_last = (b_idx == n_blk - 1);
      end
      tick();
      if (m_pt_hs) b_idx++;
      start = 1'b0;
   endtask

   task automatic new_msg(int n, logic [15:0] last_keep);
      n_blk = n;
      b_idx = 0;
      for (int i = 0; i < n; i++) begin
         b_data[i] = rnd();
         b_keep[i] = 16'hffff;
      end
      b_keep[n-1] = last_keep;
   endtask

   task automatic run_until_done(string tag, int pt_pct, int ks_pct,
                                 int ct_pct, int budget, output int cyc);
      cyc = 0;
      while (!m_done && cyc < budget) begin
         drive($urandom_range(0, 99) < pt_pct,
               $urandom_range(0, 99) < ks_pct,
               $urandom_range(0, 99) < ct_pct, rnd());
         cyc++;
      end
      chk({tag, "_timeout"}, m_done, 1'b1);
      drive(0, 0, 1, rnd());
      drive(0, 0, 1, rnd());
   endtask

   task automatic reset_checks(string tag);
      chk({tag, "_ct_valid"}, ct_valid, 0);
      chk({tag, "_ct_data"}, ct_data, 0);
      chk({tag, "_ct_keep"}, ct_keep, 0);
      chk({tag, "_ct_last"}, ct_last, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_block_cnt"}, block_cnt, 0);
      chk({tag, "_ks_ready"}, ks_ready, 0);
      chk({tag, "_pt_ready"}, pt_ready, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      int           cyc;
      logic [127:0] ks1;
      logic [127:0] exp_ct;
      #1 rst = 1'b1;
      #2 reset_checks("rst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      // single full block
      ks1 = 128'h0fffffff_ffffffff_ffffffff_ffffffff;
      new_msg(1, 16'hffff);
      b_data[0] = '0;
      start = 1'b1;
      drive(0, 0, 1, rnd());
      drive(0, 1, 1, ks1);
      run_until_done("t1", 100, 0, 100, 20, cyc);
      chk("t1_ct", ct_data, ks1);
      chk("t1_cnt", block_cnt, 1);

      // partial last block
      new_msg(1, 16'h00ff);
      b_data[0] = {16{8'haa}};
      start = 1'b1;
      drive(0, 0, 1, rnd());
      drive(0, 1, 1, {16{8'h55}});
      run_until_done("t2", 100, 0, 100, 20, cyc);
      exp_ct = {{64{1'b0}}, {64{1'b1}}};
      chk("t2_ct", ct_data, exp_ct);

      // backpressure then full-rate stream
      new_msg(8, 16'hffff);
      start = 1'b1;
      drive(0, 0, 0, rnd());
      for (int i = 0; i < 6; i++) drive(0, 1, 0, rnd());
      #1 chk("t3_full", ks_ready, 0);
      drive(1, 0, 0, rnd());
      for (int i = 0; i < 5; i++) drive(1, 0, 0, rnd());
      dut_hs_n = 0;
      run_until_done("t3", 100, 100, 100, 40, cyc);
      chk("t3_tput", cyc, 8);
      chk("t3_nblk", dut_hs_n, 8);

      // empty FIFO stalls input
      new_msg(2, 16'h0f0f);
      start = 1'b1;
      drive(0, 0, 1, rnd());
      for (int i = 0; i < 3; i++) drive(1, 0, 1, rnd());
      drive(1, 1, 1, rnd());
      #1 chk("t4_ptrdy", pt_ready, 1);
      run_until_done("t4", 100, 50, 100, 40, cyc);

      // reset mid-message
      new_msg(6, 16'hffff);
      start = 1'b1;
      drive(0, 0, 1, rnd());
      cyc = 0;
      while (b_idx < 3 && cyc < 30) begin
         drive(1, 1, 1, rnd());
         cyc++;
      end
      chk("t5_progress", b_idx, 3);
      rst = 1'b1;
      #1 reset_checks("t5");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      drive(0, 0, 1, rnd());
      new_msg(3, 16'h0001);
      start = 1'b1;
      drive(1, 0, 1, rnd());
      run_until_done("t5b", 100, 70, 100, 40, cyc);
      chk("t5_cnt", block_cnt, 3);

      // ignored start, leftover keystream discarded
      new_msg(2, 16'hffff);
      start = 1'b1;
      drive(0, 0, 1, rnd());
      drive(0, 1, 1, rnd());
      start = 1'b1;
      drive(0, 1, 1, rnd());
      run_until_done("t6", 100, 100, 100, 40, cyc);
      new_msg(1, 16'h8001);
      start = 1'b1;
      drive(1, 0, 1, rnd());
      #1 chk("t6_flush", pt_ready, 0);
      ks1 = rnd();
      drive(1, 1, 1, ks1);
      run_until_done("t6b", 100, 0, 100, 20, cyc);
      chk("t6_fresh", ct_data, ref_xor(b_data[0], ks1, b_keep[0]));

      // randomized messages
      for (int m = 0; m < 12; m++) begin
         new_msg($urandom_range(1, 8),
                 ($urandom_range(0, 3) == 0) ? 16'h0000
                                             : 16'($urandom()));
         start = 1'b1;
         drive(0, $urandom_range(0, 1), 1, rnd());
         run_until_done("rnd", 70, 60, 65, 300, cyc);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/snow_v_xor_stage.md
Name: snow_v_xor_stage

Overview:
Downstream consumer of the SNOW_V keystream core. It buffers 128-bit keystream words in a small FIFO and XORs them with a message stream of 128-bit blocks to produce ciphertext (or plaintext, since XOR is symmetric). Each block consumes exactly one keystream word. Input and output use valid/ready handshakes, and the last block of a message may be partial.

Parameters:
DATA_W, 128, block and keystream word width in bits; must be a multiple of 8.
FIFO_DEPTH, 4, keystream buffer depth in words; must be a power of 2, at least 2.
CNT_W, 32, width of the block counter.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle pulse that begins a message; honoured only in IDLE.
ks_in  in  DATA_W  keystream word from SNOW_V.
ks_valid  in  1  ks_in is valid.
ks_ready  out  1  stage accepts ks_in this cycle.
pt_data  in  DATA_W  input block.
pt_keep  in  DATA_W/8  byte enables; bit i covers bits [8i+7:8i].
pt_last  in  1  final block of the message.
pt_valid  in  1  input block is valid.
pt_ready  out  1  stage accepts the input block.
ct_data  out  DATA_W  output block.
ct_keep  out  DATA_W/8  registered copy of pt_keep.
ct_last  out  1  registered copy of pt_last.
ct_valid  out  1  output block is valid.
ct_ready  in  1  downstream accepts the output block.
busy  out  1  high in RUN and DRAIN.
done  out  1  one-cycle pulse when the last block is handed off.
block_cnt  out  CNT_W  blocks consumed in the current message.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE; FIFO empty; read and write pointers 0.
  - ct_valid=0, ct_data=0, ct_keep=0, ct_last=0.
  - done=0, block_cnt=0, ks_ready=0, pt_ready=0.
  - Reset asserted mid-message aborts the message immediately, with no done pulse.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start. On the same edge: block_cnt cleared, FIFO flushed, ct_valid cleared.
  - RUN -> DRAIN when a pt handshake occurs with pt_last=1.
  - DRAIN -> IDLE on the ct handshake (ct_valid & ct_ready). done=1 for exactly that one cycle, and the FIFO is flushed on the same edge.
  - start outside IDLE is ignored.
- Keystream side:
  - ks_ready = (state==RUN) & !fifo_full.
  - A push occurs on ks_valid & ks_ready.
  - Keystream presented while in IDLE or DRAIN is not accepted.
- Input side:
  - pt_ready = (state==RUN) & !fifo_empty & (!ct_valid | ct_ready).
  - A pt handshake pops one FIFO word, even for a partial block.
- Datapath and latency:
  - Exactly 1 cycle from pt handshake to ct_valid=1.
  - ct_data byte i = (pt_data ^ fifo_head) byte i when pt_keep[i]=1, otherwise 0x00.
  - ct_data, ct_keep and ct_last are held stable while ct_valid & !ct_ready.
  - A new block may be loaded on the same cycle the previous block is taken, giving full throughput of 1 block per clock.
  - ct_valid falls after a ct handshake if no new block is loaded on that edge.
- FIFO rules:
  - Simultaneous push and pop when non-empty and non-full: the count is unchanged and both operations take effect.
  - Push is impossible when full; pop is impossible when empty.
  - Pointers wrap modulo FIFO_DEPTH and are log2(FIFO_DEPTH)+1 bits, with the extra MSB distinguishing full from empty.
  - Words are read in arrival order.
- block_cnt:
  - Increments on each pt handshake and wraps at 2^CNT_W.
  - Holds its value in IDLE until the next start.
- pt_keep of all zeros is legal: the keystream word is still consumed and ct_data is 0.

Decomposition:
- Package snow_v_pkg holds:
  - the constants SNOW_V_BLK_W=128 and SNOW_V_KEEP_W=16;
  - the state enum (IDLE, RUN, DRAIN).
- One sub-module, snow_v_ks_fifo: a synchronous FIFO with ports push, pop, din, dout (head, first-word-fall-through), full, empty, flush, and asynchronous rst.
- XOR/mask logic and the FSM stay in the top level.

Test Plan:
1. Single full block: start; ks_in=0x0f…ff ×1; pt_data=0x00…00, keep=0xFFFF, last=1.
   -> ct_data=ks word 1 cycle after the pt handshake; ct_last=1; done pulses on the ct handshake; block_cnt=1; state returns to IDLE.
2. Partial last block: keep=0x00FF, pt=all 0xAA, ks=all 0x55.
   -> ct low 8 bytes=0xFF, high 8 bytes=0x00; the FIFO word is consumed.
3. Backpressure: ct_ready=0 for 5 cycles with 6 keystream words offered.
   -> ks_ready falls after 4 pushes; ct_data is held stable; pt_ready=0.
   -> Release ct_ready: the output stream resumes at 1 block per clock with no loss or duplication. Check against a reference XOR model over 8 blocks.
4. Empty FIFO: pt_valid=1 while ks_valid=0.
   -> pt_ready=0 and ct_valid stays 0. When the first ks word arrives, pt_ready=1 on the next cycle.
5. Reset mid-message: assert rst after 3 blocks.
   -> All outputs reach their reset values immediately, with no done pulse. The next start gives block_cnt counting from 0 and an empty FIFO.
6. Ignored start and leftover flush: start pulsed during RUN has no effect. Keystream words left in the FIFO after done are discarded, and the next message uses fresh words.
